// File: rtl/sort_pkg.sv
// ----------------------------------------------------------------------------
// sort_pkg
//   Shared definitions for the sort4 / sort4_unsort pipeline stages and their
//   benches.
//   - VAL_W / IDX_W : width of the signed value field and unsigned index field.
//   - N             : entries per frame.
//   - IDX_BASE      : index carried by the first slot (legal range
//                     IDX_BASE .. IDX_BASE+N-1).
//   - entry_t       : {signed value, index}, value in the upper bits.
//   - state_t       : frame FSM states of sort4_unsort.
// ----------------------------------------------------------------------------
package sort_pkg;

    localparam int VAL_W    = 6;
    localparam int IDX_W    = 5;
    localparam int N        = 4;
    localparam int IDX_BASE = 1;

    localparam int ENT_W  = VAL_W + IDX_W;
    localparam int SLOT_W = $clog2(N);
    // One extra bit so a counter can hold the value N itself.
    localparam int CNT_W  = $clog2(N) + 1;

    typedef struct packed {
        logic signed [VAL_W-1:0] val;
        logic        [IDX_W-1:0] idx;
    } entry_t;

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_t;

    // Index carried by a given slot; unwritten slots report this index.
    function automatic logic [IDX_W-1:0] slot_to_idx(input logic [SLOT_W-1:0] slot);
        return IDX_W'(IDX_BASE) + IDX_W'(slot);
    endfunction

endpackage

// File: rtl/sort4_unsort_slotbuf.sv
// ----------------------------------------------------------------------------
// sort4_unsort_slotbuf
//   N-entry register file addressed by the index field of the written entry.
//   Keeps a written-bitmap, decodes the index into a one-hot slot select,
//   flags out-of-range and duplicate writes, and presents the selected slot
//   (or, for an unwritten slot, a zero value carrying that slot's own index)
//   on the read port.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (clears slots and bitmap)
//   wr_en_i    in   write the entry on wr_data_i this cycle
//   wr_data_i  in   {value, index} entry to scatter
//   clr_i      in   clear the written-bitmap (end of frame)
//   rd_slot_i  in   slot number to read
//   rd_data_o  out  slot contents, or {0, slot index} when slot unwritten
//   wr_bad_o   out  current write has an out-of-range or duplicate index
// ----------------------------------------------------------------------------
module sort4_unsort_slotbuf
    import sort_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ENT_W-1:0]  wr_data_i,
    input  logic              clr_i,
    input  logic [SLOT_W-1:0] rd_slot_i,
    output logic [ENT_W-1:0]  rd_data_o,
    output logic              wr_bad_o
);

    entry_t         wr_ent;
    logic [N-1:0]   hit;
    logic [N-1:0]   bitmap_q;
    logic [N-1:0]   bitmap_d;
    entry_t         slot_q [N];
    entry_t         rd_ent;

    assign wr_ent = entry_t'(wr_data_i);

    // One-hot decode of the index field. An index outside the legal window
    // hits no slot, so the range check falls out of the decode for free.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slot
            assign hit[gi] = (wr_ent.idx == IDX_W'(IDX_BASE + gi));

            // Clear wins: it only fires on the last drain handshake, when
            // no write can be in progress anyway.
            assign bitmap_d[gi] = clr_i                 ? 1'b0 :
                                  (wr_en_i && hit[gi])  ? 1'b1 :
                                                          bitmap_q[gi];
        end
    endgenerate

    // Out of range (no slot hit) or the hit slot is already marked written.
    assign wr_bad_o = wr_en_i && ((hit == '0) || ((hit & bitmap_q) != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q <= '0;
        end else begin
            bitmap_q <= bitmap_d;
        end
    end

    // A duplicate write simply overwrites: the later entry wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                slot_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < N; i++) begin
                if (hit[i]) begin
                    slot_q[i] <= wr_ent;
                end
            end
        end
    end

    // Slot contents are only trusted when the bitmap says they belong to
    // the current frame; stale data from an earlier frame never leaks out.
    always_comb begin
        rd_ent.val = '0;
        rd_ent.idx = slot_to_idx(rd_slot_i);
        if (bitmap_q[rd_slot_i]) begin
            rd_ent = slot_q[rd_slot_i];
        end
    end

    assign rd_data_o = rd_ent;

endmodule

// File: rtl/sort4_unsort.sv
// ----------------------------------------------------------------------------
// sort4_unsort
//   Restores original lane order after a sort4 stage. Entries {value, index}
//   arrive serially in sorted order; each is scattered into the slot named by
//   its index. Once N entries have been accepted the frame is streamed out in
//   ascending index order. Bad or duplicate indices are flagged per entry
//   (idx_err) and per frame (frame_err); missing slots come out as value 0.
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset; discards any partial frame
//   in_valid   in   input entry valid
//   in_ready   out  accepting input (COLLECT state only)
//   in_data    in   {value, index} in sorted order
//   out_valid  out  output entry valid (DRAIN state only)
//   out_ready  in   downstream accepts output entry
//   out_data   out  {value, index} in index order; 0 when not valid
//   out_last   out  final entry of the frame (qualified by out_valid)
//   idx_err    out  one-cycle pulse after accepting a bad/duplicate index
//   frame_err  out  sticky for the frame being collected/drained
// ----------------------------------------------------------------------------
module sort4_unsort
    import sort_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ENT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ENT_W-1:0] out_data,
    output logic             out_last,
    output logic             idx_err,
    output logic             frame_err
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] acc_cnt_q;
    logic [CNT_W-1:0] acc_cnt_d;
    logic [CNT_W-1:0] out_cnt_q;
    logic [CNT_W-1:0] out_cnt_d;
    logic             idx_err_q;
    logic             idx_err_d;
    logic             frame_err_q;
    logic             frame_err_d;

    logic             accept;
    logic             emit;
    logic             last_slot;
    logic             emit_last;
    logic             wr_bad;
    logic [ENT_W-1:0] rd_data;

    // Handshake qualifiers come straight from the state register, so
    // in_ready never depends on in_valid and out_valid never on out_ready.
    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == DRAIN);

    assign accept    = in_valid  && in_ready;
    assign emit      = out_valid && out_ready;
    assign last_slot = (out_cnt_q == CNT_W'(N - 1));
    assign emit_last = emit && last_slot;

    sort4_unsort_slotbuf u_slotbuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (accept),
        .wr_data_i (in_data),
        .clr_i     (emit_last),
        .rd_slot_i (out_cnt_q[SLOT_W-1:0]),
        .rd_data_o (rd_data),
        .wr_bad_o  (wr_bad)
    );

    // Next-state / counter logic.
    always_comb begin
        state_d     = state_q;
        acc_cnt_d   = acc_cnt_q;
        out_cnt_d   = out_cnt_q;
        idx_err_d   = accept && wr_bad;
        frame_err_d = frame_err_q || (accept && wr_bad);

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (acc_cnt_q < CNT_W'(N)) begin
                        acc_cnt_d = acc_cnt_q + CNT_W'(1);
                    end
                    // Bad entries still count toward the frame length.
                    if (acc_cnt_q == CNT_W'(N - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (emit) begin
                    if (last_slot) begin
                        state_d     = COLLECT;
                        acc_cnt_d   = '0;
                        out_cnt_d   = '0;
                        frame_err_d = 1'b0;
                    end else begin
                        out_cnt_d = out_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            acc_cnt_q   <= '0;
            out_cnt_q   <= '0;
            idx_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            out_cnt_q   <= out_cnt_d;
            idx_err_q   <= idx_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Read port follows out_cnt_q, which only moves on a handshake, so data
    // and last stay stable while the consumer stalls.
    assign out_data  = out_valid ? rd_data : '0;
    assign out_last  = out_valid && last_slot;
    assign idx_err   = idx_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_sort4_unsort.sv
// ----------------------------------------------------------------------------
// tb_sort4_unsort
//   Directed frames from a vector table, each entry with its hand-computed
//   expected output order and per-entry index-error flags, plus a hand-written
//   reset-mid-frame sequence.
// ----------------------------------------------------------------------------
module tb_sort4_unsort;
    import sort_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [ENT_W-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ENT_W-1:0] out_data;
    logic             out_last;
    logic             idx_err;
    logic             frame_err;

    int n_vec = 0;
    int n_mis = 0;

    sort4_unsort dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .idx_err   (idx_err),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][ENT_W-1:0] in_d;   // [k] = k-th entry sent
        logic [3:0][ENT_W-1:0] exp_d;  // [k] = k-th entry expected out
        logic [3:0]            errs;   // [k] = k-th accept flags idx_err
        logic                  stall;  // random out_ready back-pressure
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];
    vec_t vrst;

    function automatic logic [ENT_W-1:0] ent(input int v, input int i);
        logic [ENT_W-1:0] r;
        r = {v[VAL_W-1:0], i[IDX_W-1:0]};
        return r;
    endfunction

    function automatic logic [3:0][ENT_W-1:0] mk4(input logic [ENT_W-1:0] a,
                                                  input logic [ENT_W-1:0] b,
                                                  input logic [ENT_W-1:0] c,
                                                  input logic [ENT_W-1:0] d);
        logic [3:0][ENT_W-1:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Present one entry, wait for in_ready, take the accept edge, then check
    // the idx_err pulse and sticky frame_err that follow it.
    task automatic send(input logic [ENT_W-1:0] d, input logic exp_err, input logic exp_ferr);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) chk("in_ready_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = '0;
        $display("send  %h -> idx_err=%0d frame_err=%0d", d, idx_err, frame_err);
        chk("idx_err", idx_err, exp_err);
        chk("frame_err_collect", frame_err, exp_ferr);
    endtask

    task automatic drain(input vec_t v);
        logic [ENT_W-1:0] prev_d;
        logic             prev_l;
        logic             prev_stall;
        logic             done;
        int               t;
        prev_d     = '0;
        prev_l     = 1'b0;
        prev_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            done = 1'b0;
            t    = 0;
            while (!done && t < 200) begin
                out_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
                chk("in_ready_drain", in_ready, 1'b0);
                if (prev_stall) begin
                    chk("stall_data_stable", out_data, prev_d);
                    chk("stall_last_stable", out_last, prev_l);
                end
                if (out_valid && out_ready) begin
                    $display("recv  %h last=%0d frame_err=%0d", out_data, out_last, frame_err);
                    chk("out_data", out_data, v.exp_d[k]);
                    chk("out_last", out_last, (k == 3));
                    chk("frame_err_drain", frame_err, |v.errs);
                    done       = 1'b1;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = out_valid;
                    prev_d     = out_data;
                    prev_l     = out_last;
                end
                @(posedge clk); #1;
                t++;
            end
            if (!done) chk("drain_timeout", 32'd1, 32'd0);
        end
        out_ready = 1'b0;
        chk("out_valid_after_frame", out_valid, 1'b0);
        chk("in_ready_after_frame", in_ready, 1'b1);
        chk("frame_err_cleared", frame_err, 1'b0);
    endtask

    task automatic run_vec(input vec_t v);
        logic ferr;
        ferr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ferr = ferr | v.errs[k];
            send(v.in_d[k], v.errs[k], ferr);
            if (k < 3) chk("out_valid_collect", out_valid, 1'b0);
        end
        // Latency 1: valid in the cycle right after the 4th accept edge.
        chk("out_valid_latency", out_valid, 1'b1);
        chk("in_ready_low_drain", in_ready, 1'b0);
        drain(v);
    endtask

    initial begin
        // Basic frame, no back-pressure.
        vecs[0].in_d  = mk4(ent(4,1), ent(-2,2), ent(-11,4), ent(-32,3));
        vecs[0].exp_d = mk4(ent(4,1), ent(-2,2), ent(-32,3), ent(-11,4));
        vecs[0].errs  = 4'b0000;
        vecs[0].stall = 1'b0;
        // Same frame with random back-pressure.
        vecs[1]       = vecs[0];
        vecs[1].stall = 1'b1;
        // Out-of-range index 7 on 2nd entry; slot 2 comes out empty.
        vecs[2].in_d  = mk4(ent(5,1), ent(6,7), ent(7,3), ent(8,4));
        vecs[2].exp_d = mk4(ent(5,1), ent(0,2), ent(7,3), ent(8,4));
        vecs[2].errs  = 4'b0010;
        vecs[2].stall = 1'b0;
        // Duplicate index 2: later entry wins, slot 4 empty.
        vecs[3].in_d  = mk4(ent(1,2), ent(2,2), ent(3,1), ent(4,3));
        vecs[3].exp_d = mk4(ent(3,1), ent(2,2), ent(4,3), ent(0,4));
        vecs[3].errs  = 4'b0010;
        vecs[3].stall = 1'b0;
        // Clean frame right after an errored one.
        vecs[4]       = vecs[0];
        // Fully reversed order, extreme positive value, stalled.
        vecs[5].in_d  = mk4(ent(-1,4), ent(3,3), ent(2,2), ent(31,1));
        vecs[5].exp_d = mk4(ent(31,1), ent(2,2), ent(3,3), ent(-1,4));
        vecs[5].errs  = 4'b0000;
        vecs[5].stall = 1'b1;
        // Index 0 is just below the legal window.
        vecs[6].in_d  = mk4(ent(9,0), ent(1,1), ent(2,2), ent(3,3));
        vecs[6].exp_d = mk4(ent(1,1), ent(2,2), ent(3,3), ent(0,4));
        vecs[6].errs  = 4'b0001;
        vecs[6].stall = 1'b0;
        // After reset mid-frame: slots 1/2 must not show the stale entries.
        vrst.in_d     = mk4(ent(1,3), ent(2,3), ent(3,4), ent(4,4));
        vrst.exp_d    = mk4(ent(0,1), ent(0,2), ent(2,3), ent(4,4));
        vrst.errs     = 4'b1010;
        vrst.stall    = 1'b0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state.
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_idx_err", idx_err, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_no_output", out_valid, 1'b0);

        for (int v = 0; v < NV; v++) begin
            $display("frame %0d", v);
            run_vec(vecs[v]);
        end

        // Reset after two accepts; the partial frame must vanish.
        $display("frame reset-mid-op");
        send(ent(11,1), 1'b0, 1'b0);
        send(ent(12,2), 1'b0, 1'b0);
        rst_n = 1'b0;
        #3;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_frame_err", frame_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(vrst);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
